// File: rtl/cordic_kernel_arbiter_pkg.sv
// Shared settings for the CORDIC kernel arbiter slice.
// Holds the default datapath widths, the default channel count and in-flight
// depth, and a channel-index type sized for the default channel count.
package package_settings;

    localparam int PKG_NUM_CHANNELS = 4;
    localparam int PKG_DATA_WIDTH   = 16;
    localparam int PKG_THETA_WIDTH  = 16;
    localparam int PKG_MAX_INFLIGHT = 16;

    typedef logic [$clog2(PKG_NUM_CHANNELS)-1:0] chan_idx_t;

endpackage

// File: rtl/cordic_kernel_arbiter_tag_fifo.sv
// cordic_tag_fifo: synchronous FIFO of channel tags.
// Records which channel issued each kernel sample so results can be routed
// back in issue order.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   push_i/push_tag_i write a tag (ignored when full)
//   pop_i             discard the head tag (ignored when empty)
//   head_tag_o        current head tag, valid whenever empty_o is low
//   full_o/empty_o    occupancy flags
//   count_o           number of stored tags (0..DEPTH)
module cordic_tag_fifo
    import package_settings::*;
#(
    parameter int DEPTH     = PKG_MAX_INFLIGHT,
    parameter int TAG_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [TAG_WIDTH-1:0]       push_tag_i,
    input  logic                       pop_i,
    output logic [TAG_WIDTH-1:0]       head_tag_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [TAG_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic                 do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // The head must be visible in the same cycle a result arrives, so the
    // small tag array is read asynchronously rather than through a register.
    assign head_tag_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_tag_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cordic_kernel_arbiter.sv
// cordic_kernel_arbiter: shares one cordic_kernel between NUM_CHANNELS
// requesters with round-robin arbitration, and routes each kernel result back
// to the channel that issued it, in issue order.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   req_valid/req_ready         per-channel handshake (ready is one-hot or 0)
//   req_data_i/req_data_q       per-channel samples, channel k at slice k
//   kernel_data_i/q, _enable    registered sample issued to the kernel
//   kernel_output_data_*        kernel result inputs
//   res_valid (one-hot), res_data_i/q/theta, res_channel   routed result
//   inflight_count              samples issued and not yet returned
//   err_orphan                  sticky: result arrived with no tag pending
module cordic_kernel_arbiter
    import package_settings::*;
#(
    parameter int NUM_CHANNELS = PKG_NUM_CHANNELS,
    parameter int DATA_WIDTH   = PKG_DATA_WIDTH,
    parameter int THETA_WIDTH  = PKG_THETA_WIDTH,
    parameter int MAX_INFLIGHT = PKG_MAX_INFLIGHT
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CHANNELS-1:0]            req_valid,
    output logic [NUM_CHANNELS-1:0]            req_ready,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] req_data_q,
    output logic [DATA_WIDTH-1:0]              kernel_data_i,
    output logic [DATA_WIDTH-1:0]              kernel_data_q,
    output logic                               kernel_enable,
    input  logic [DATA_WIDTH-1:0]              kernel_output_data_i,
    input  logic [DATA_WIDTH-1:0]              kernel_output_data_q,
    input  logic [THETA_WIDTH-1:0]             kernel_output_data_theta,
    input  logic                               kernel_output_data_valid,
    output logic [NUM_CHANNELS-1:0]            res_valid,
    output logic [DATA_WIDTH-1:0]              res_data_i,
    output logic [DATA_WIDTH-1:0]              res_data_q,
    output logic [THETA_WIDTH-1:0]             res_data_theta,
    output logic [$clog2(NUM_CHANNELS)-1:0]    res_channel,
    output logic [$clog2(MAX_INFLIGHT):0]      inflight_count,
    output logic                               err_orphan
);

    localparam int CW = $clog2(NUM_CHANNELS);
    localparam logic [NUM_CHANNELS-1:0] ONE = {{(NUM_CHANNELS-1){1'b0}}, 1'b1};

    // Per-channel views of the packed sample buses.
    logic [DATA_WIDTH-1:0] ch_data_i [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0] ch_data_q [NUM_CHANNELS];

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_unpack
        assign ch_data_i[gi] = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign ch_data_q[gi] = req_data_q[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    logic [CW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] grant_idx;
    logic [CW-1:0] cand_idx;
    logic          grant_found;
    logic          issue_fire;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] head_tag;
    logic          pop_fire;

    // Round-robin search: start just after the last winner and wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int i = 1; i <= NUM_CHANNELS; i++) begin
            cand_idx = CW'((int'(ptr_q) + i) % NUM_CHANNELS);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Ready depends only on the registered occupancy; a same-cycle pop does
    // not free a slot until the next cycle.
    assign issue_fire = grant_found && !fifo_full;
    assign req_ready  = issue_fire ? (ONE << grant_idx) : '0;
    assign ptr_d      = issue_fire ? grant_idx : ptr_q;

    // A result with no pending tag is an orphan: flagged, never popped.
    assign pop_fire = kernel_output_data_valid && !fifo_empty;

    cordic_tag_fifo #(
        .DEPTH     (MAX_INFLIGHT),
        .TAG_WIDTH (CW)
    ) u_tag_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (issue_fire),
        .push_tag_i (grant_idx),
        .pop_i      (pop_fire),
        .head_tag_o (head_tag),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (inflight_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q          <= CW'(NUM_CHANNELS - 1);
            kernel_enable  <= 1'b0;
            kernel_data_i  <= '0;
            kernel_data_q  <= '0;
            res_valid      <= '0;
            res_data_i     <= '0;
            res_data_q     <= '0;
            res_data_theta <= '0;
            res_channel    <= '0;
            err_orphan     <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            kernel_enable <= issue_fire;
            if (issue_fire) begin
                kernel_data_i <= ch_data_i[grant_idx];
                kernel_data_q <= ch_data_q[grant_idx];
            end
            res_valid <= pop_fire ? (ONE << head_tag) : '0;
            if (pop_fire) begin
                res_data_i     <= kernel_output_data_i;
                res_data_q     <= kernel_output_data_q;
                res_data_theta <= kernel_output_data_theta;
                res_channel    <= head_tag;
            end
            if (kernel_output_data_valid && fifo_empty) err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cordic_kernel_arbiter.sv
// Directed testbench for cordic_kernel_arbiter; the bench itself plays the
// role of the cordic_kernel by driving kernel_output_* directly.
module tb_cordic_kernel_arbiter;
    import package_settings::*;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int TW = 16;
    localparam int MI = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data_i;
    logic [N*DW-1:0] req_data_q;
    logic [DW-1:0]   kernel_data_i;
    logic [DW-1:0]   kernel_data_q;
    logic            kernel_enable;
    logic [DW-1:0]   kout_i;
    logic [DW-1:0]   kout_q;
    logic [TW-1:0]   kout_theta;
    logic            kout_valid;
    logic [N-1:0]    res_valid;
    logic [DW-1:0]   res_data_i;
    logic [DW-1:0]   res_data_q;
    logic [TW-1:0]   res_data_theta;
    chan_idx_t       res_channel;
    logic [4:0]      inflight_count;
    logic            err_orphan;

    int asserts  = 0;
    int failures = 0;

    cordic_kernel_arbiter #(
        .NUM_CHANNELS (N),
        .DATA_WIDTH   (DW),
        .THETA_WIDTH  (TW),
        .MAX_INFLIGHT (MI)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .req_valid                (req_valid),
        .req_ready                (req_ready),
        .req_data_i               (req_data_i),
        .req_data_q               (req_data_q),
        .kernel_data_i            (kernel_data_i),
        .kernel_data_q            (kernel_data_q),
        .kernel_enable            (kernel_enable),
        .kernel_output_data_i     (kout_i),
        .kernel_output_data_q     (kout_q),
        .kernel_output_data_theta (kout_theta),
        .kernel_output_data_valid (kout_valid),
        .res_valid                (res_valid),
        .res_data_i               (res_data_i),
        .res_data_q               (res_data_q),
        .res_data_theta           (res_data_theta),
        .res_channel              (res_channel),
        .inflight_count           (inflight_count),
        .err_orphan               (err_orphan)
    );

    always #5 clk = ~clk;

    // One line per transaction: issues to the kernel and routed results.
    always @(negedge clk) begin
        if (!reset && kernel_enable)
            $display("[%0t] issue  data_i=%h data_q=%h count=%0d", $time, kernel_data_i, kernel_data_q, inflight_count);
        if (!reset && |res_valid)
            $display("[%0t] result ch=%0d i=%h q=%h theta=%h", $time, res_channel, res_data_i, res_data_q, res_data_theta);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        @(negedge clk);
        reset      = 1'b1;
        req_valid  = '0;
        kout_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_samples;
        for (int k = 0; k < N; k++) begin
            req_data_i[k*DW +: DW] = 16'h1000 + 16'(k);
            req_data_q[k*DW +: DW] = 16'h2000 + 16'(k);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        asserts++; if (kernel_enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", kernel_enable); end
        asserts++; if (kernel_data_i !== 16'h0) begin failures++; $display("FAIL reset_kdata got=%h exp=0", kernel_data_i); end
        asserts++; if (res_valid !== 4'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        asserts++; if (res_data_theta !== 16'h0) begin failures++; $display("FAIL reset_theta got=%h exp=0", res_data_theta); end
        asserts++; if (inflight_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", inflight_count); end
        asserts++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_orphan); end
        asserts++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    endtask

    task automatic test_single;
        do_reset();
        req_data_i[2*DW +: DW] = 16'h1000;
        req_data_q[2*DW +: DW] = 16'h0000;
        req_valid = 4'b0100;
        #1;
        asserts++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        asserts++; if (kernel_enable !== 1'b1) begin failures++; $display("FAIL single_enable got=%b exp=1", kernel_enable); end
        asserts++; if (kernel_data_i !== 16'h1000) begin failures++; $display("FAIL single_kdata_i got=%h exp=1000", kernel_data_i); end
        asserts++; if (kernel_data_q !== 16'h0000) begin failures++; $display("FAIL single_kdata_q got=%h exp=0000", kernel_data_q); end
        asserts++; if (inflight_count !== 5'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", inflight_count); end
        kout_valid = 1'b1; kout_i = 16'h0ABC; kout_q = 16'h0DEF; kout_theta = 16'h2000;
        @(negedge clk);
        kout_valid = 1'b0;
        asserts++; if (res_valid !== 4'b0100) begin failures++; $display("FAIL single_res_valid got=%b exp=0100", res_valid); end
        asserts++; if (res_channel !== 2'd2) begin failures++; $display("FAIL single_res_ch got=%0d exp=2", res_channel); end
        asserts++; if (res_data_i !== 16'h0ABC) begin failures++; $display("FAIL single_res_i got=%h exp=0abc", res_data_i); end
        asserts++; if (res_data_q !== 16'h0DEF) begin failures++; $display("FAIL single_res_q got=%h exp=0def", res_data_q); end
        asserts++; if (res_data_theta !== 16'h2000) begin failures++; $display("FAIL single_res_theta got=%h exp=2000", res_data_theta); end
        asserts++; if (inflight_count !== 5'd0) begin failures++; $display("FAIL single_count_ret got=%0d exp=0", inflight_count); end
        asserts++; if (kernel_enable !== 1'b0) begin failures++; $display("FAIL single_enable_idle got=%b exp=0", kernel_enable); end
        @(negedge clk);
        asserts++; if (res_valid !== 4'b0) begin failures++; $display("FAIL single_res_drop got=%b exp=0", res_valid); end
        asserts++; if (res_data_i !== 16'h0ABC) begin failures++; $display("FAIL single_res_hold got=%h exp=0abc", res_data_i); end
    endtask

    task automatic test_round_robin;
        chan_idx_t  e_ch;
        logic [3:0] e_oh;
        do_reset();
        load_samples();
        req_valid = 4'hF;
        for (int j = 0; j < 8; j++) begin
            e_ch = chan_idx_t'(j % 4);
            e_oh = 4'b0001 << e_ch;
            #1;
            asserts++; if (req_ready !== e_oh) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", j, req_ready, e_oh); end
            @(negedge clk);
            asserts++; if (kernel_data_i !== 16'h1000 + 16'(e_ch)) begin failures++; $display("FAIL rr_kdata[%0d] got=%h exp=%h", j, kernel_data_i, 16'h1000 + 16'(e_ch)); end
        end
        req_valid = '0;
        asserts++; if (inflight_count !== 5'd8) begin failures++; $display("FAIL rr_count got=%0d exp=8", inflight_count); end
        for (int j = 0; j < 8; j++) begin
            kout_valid = 1'b1; kout_i = 16'h0100 + 16'(j); kout_q = 16'h0200 + 16'(j); kout_theta = 16'h0300 + 16'(j);
            @(negedge clk);
            e_ch = chan_idx_t'(j % 4);
            e_oh = 4'b0001 << e_ch;
            asserts++; if (res_valid !== e_oh) begin failures++; $display("FAIL rr_res_valid[%0d] got=%b exp=%b", j, res_valid, e_oh); end
            asserts++; if (res_channel !== e_ch) begin failures++; $display("FAIL rr_res_ch[%0d] got=%0d exp=%0d", j, res_channel, e_ch); end
            asserts++; if (res_data_theta !== 16'h0300 + 16'(j)) begin failures++; $display("FAIL rr_res_theta[%0d] got=%h exp=%h", j, res_data_theta, 16'h0300 + 16'(j)); end
        end
        kout_valid = 1'b0;
        @(negedge clk);
        asserts++; if (inflight_count !== 5'd0) begin failures++; $display("FAIL rr_count_end got=%0d exp=0", inflight_count); end
        asserts++; if (res_valid !== 4'b0) begin failures++; $display("FAIL rr_res_idle got=%b exp=0", res_valid); end
    endtask

    task automatic test_full;
        do_reset();
        load_samples();
        req_valid = 4'hF;
        repeat (16) @(negedge clk);
        #1;
        asserts++; if (inflight_count !== 5'd16) begin failures++; $display("FAIL full_count got=%0d exp=16", inflight_count); end
        asserts++; if (req_ready !== 4'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", req_ready); end
        @(negedge clk);
        asserts++; if (kernel_enable !== 1'b0) begin failures++; $display("FAIL full_enable got=%b exp=0", kernel_enable); end
        asserts++; if (inflight_count !== 5'd16) begin failures++; $display("FAIL full_count_hold got=%0d exp=16", inflight_count); end
        kout_valid = 1'b1; kout_i = 16'h5555; kout_q = 16'h6666; kout_theta = 16'h7777;
        #1;
        asserts++; if (req_ready !== 4'b0) begin failures++; $display("FAIL full_ready_pop got=%b exp=0", req_ready); end
        @(negedge clk);
        kout_valid = 1'b0;
        #1;
        asserts++; if (inflight_count !== 5'd15) begin failures++; $display("FAIL full_count_pop got=%0d exp=15", inflight_count); end
        asserts++; if (res_valid !== 4'b0001) begin failures++; $display("FAIL full_res_valid got=%b exp=0001", res_valid); end
        asserts++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL full_ready_resume got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        asserts++; if (kernel_enable !== 1'b1) begin failures++; $display("FAIL full_enable_resume got=%b exp=1", kernel_enable); end
        asserts++; if (inflight_count !== 5'd16) begin failures++; $display("FAIL full_count_refill got=%0d exp=16", inflight_count); end
    endtask

    task automatic test_simultaneous;
        chan_idx_t order [5];
        order = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        load_samples();
        req_valid = 4'hF;
        repeat (5) @(negedge clk);
        req_valid  = 4'b0010;
        kout_valid = 1'b1; kout_theta = 16'h0700;
        #1;
        asserts++; if (inflight_count !== 5'd5) begin failures++; $display("FAIL simul_count_pre got=%0d exp=5", inflight_count); end
        asserts++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL simul_ready got=%b exp=0010", req_ready); end
        @(negedge clk);
        req_valid  = '0;
        kout_valid = 1'b0;
        asserts++; if (inflight_count !== 5'd5) begin failures++; $display("FAIL simul_count got=%0d exp=5", inflight_count); end
        asserts++; if (res_channel !== 2'd0) begin failures++; $display("FAIL simul_res_ch got=%0d exp=0", res_channel); end
        asserts++; if (kernel_data_i !== 16'h1001) begin failures++; $display("FAIL simul_kdata got=%h exp=1001", kernel_data_i); end
        for (int j = 0; j < 5; j++) begin
            kout_valid = 1'b1; kout_theta = 16'h0710 + 16'(j);
            @(negedge clk);
            asserts++; if (res_channel !== order[j]) begin failures++; $display("FAIL simul_order[%0d] got=%0d exp=%0d", j, res_channel, order[j]); end
        end
        kout_valid = 1'b0;
        @(negedge clk);
        asserts++; if (inflight_count !== 5'd0) begin failures++; $display("FAIL simul_count_end got=%0d exp=0", inflight_count); end
    endtask

    task automatic test_orphan;
        do_reset();
        kout_valid = 1'b1; kout_theta = 16'h0BAD;
        @(negedge clk);
        kout_valid = 1'b0;
        asserts++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_set got=%b exp=1", err_orphan); end
        asserts++; if (res_valid !== 4'b0) begin failures++; $display("FAIL orphan_res got=%b exp=0", res_valid); end
        asserts++; if (inflight_count !== 5'd0) begin failures++; $display("FAIL orphan_count got=%0d exp=0", inflight_count); end
        repeat (10) @(negedge clk);
        asserts++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_sticky got=%b exp=1", err_orphan); end
        do_reset();
        asserts++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL orphan_clear got=%b exp=0", err_orphan); end
    endtask

    task automatic test_reset_midflight;
        do_reset();
        load_samples();
        req_valid = 4'hF;
        repeat (6) @(negedge clk);
        asserts++; if (inflight_count !== 5'd6) begin failures++; $display("FAIL mid_count_pre got=%0d exp=6", inflight_count); end
        req_valid = '0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        asserts++; if (inflight_count !== 5'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", inflight_count); end
        asserts++; if (res_valid !== 4'b0) begin failures++; $display("FAIL mid_res got=%b exp=0", res_valid); end
        asserts++; if (kernel_enable !== 1'b0) begin failures++; $display("FAIL mid_enable got=%b exp=0", kernel_enable); end
        req_valid = 4'hF;
        #1;
        asserts++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_priority got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_data_i = '0;
        req_data_q = '0;
        kout_valid = 1'b0;
        kout_i     = '0;
        kout_q     = '0;
        kout_theta = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_simultaneous();
        test_orphan();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
